session_scheduler: RTL and testbench

- Sequences one training session: time-shares the single ADC between the temperature channel and the pulse channel.
- Packages each sample pair into a record and hands it to the database writer over valid/ready.
- Sits between the top-level start/stop button, the ADC front end, and the logging path; replaces the free-running request flags in the top level.

---
 rtl/cycle_trainer_pkg.sv | 22 ++
 rtl/adc_watchdog.sv | 36 +++
 rtl/session_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_session_scheduler.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cycle_trainer_pkg.sv
// Shared types and constants for the training-session scheduler.
package cycle_trainer_pkg;

    localparam int unsigned ADC_W = 12;
    localparam int unsigned SEQ_W = 8;

    localparam logic CH_TEMP  = 1'b0;
    localparam logic CH_PULSE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        REQ_TEMP,
        REQ_PULSE,
        LOG,
        WAIT
    } state_e;

    function automatic logic is_req(input state_e s);
        return (s == REQ_TEMP) || (s == REQ_PULSE);
    endfunction

endpackage

// File: rtl/adc_watchdog.sv
// Counts unacknowledged cycles of an outstanding ADC request; expire fires on the
// last permitted cycle so the scheduler abandons the request at the following edge.
module adc_watchdog #(
    parameter int unsigned ADC_TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic arm,
    input  logic ack,
    output logic expire
);
    localparam int unsigned CW = $clog2(ADC_TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // An ack ends the current request, so the next channel starts from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (!arm || ack) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(ADC_TIMEOUT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = arm & ~ack & (cnt_q == CW'(ADC_TIMEOUT - 1));

endmodule

// File: rtl/session_scheduler.sv
// Sequences a training session: temperature then pulse conversion, then one logged record.
// Optional SESSION_STATS_EN adds a saturating per-session record_count output.
module session_scheduler #(
    parameter int unsigned ADC_W         = cycle_trainer_pkg::ADC_W,
    parameter int unsigned SAMPLE_PERIOD = 1000,
    parameter int unsigned ADC_TIMEOUT   = 255
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             button,
    input  logic                             adc_ack,
    input  logic [ADC_W-1:0]                 adc_data,
    output logic                             adc_req,
    output logic                             adc_ch,
    input  logic                             db_ready,
    output logic                             db_valid,
    output logic [ADC_W-1:0]                 db_temp,
    output logic [ADC_W-1:0]                 db_pulse,
    output logic [cycle_trainer_pkg::SEQ_W-1:0] db_seq,
    output logic                             active,
    output logic                             fault
`ifdef SESSION_STATS_EN
    ,
    output logic [15:0]                      record_count
`endif
);
    import cycle_trainer_pkg::*;

    localparam int unsigned WAIT_W = $clog2(SAMPLE_PERIOD);

    state_e             state_q, state_d;
    logic               button_q;
    logic               stop_pend_q, stop_pend_d;
    logic [ADC_W-1:0]   temp_q, temp_d;
    logic [ADC_W-1:0]   pulse_q, pulse_d;
    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               fault_q, fault_d;
    logic               adc_req_q, adc_req_d;
    logic               adc_ch_q, adc_ch_d;
    logic               db_valid_q, db_valid_d;
    logic               active_q, active_d;

    logic btn_edge, start, stop_now, ack, xfer, arm, expire;

    assign btn_edge = button & ~button_q;
    assign start    = (state_q == IDLE) & btn_edge;
    assign stop_now = stop_pend_q | btn_edge;
    assign ack      = adc_ack & adc_req_q;
    assign xfer     = db_valid_q & db_ready;
    assign arm      = is_req(state_q);

    adc_watchdog #(
        .ADC_TIMEOUT (ADC_TIMEOUT)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .arm    (arm),
        .ack    (ack),
        .expire (expire)
    );

    always_comb begin
        state_d     = state_q;
        stop_pend_d = stop_pend_q;
        temp_d      = temp_q;
        pulse_d     = pulse_q;
        seq_d       = seq_q;
        wait_d      = wait_q;
        fault_d     = fault_q;
        unique case (state_q)
            IDLE: begin
                if (btn_edge) begin
                    state_d = REQ_TEMP;
                    fault_d = 1'b0;
                end
            end
            REQ_TEMP, REQ_PULSE: begin
                // An ack always beats a same-cycle timeout; a stop only takes effect on the ack.
                if (ack) begin
                    if (state_q == REQ_TEMP) begin
                        temp_d = adc_data;
                    end else begin
                        pulse_d = adc_data;
                    end
                    stop_pend_d = 1'b0;
                    if (stop_now) begin
                        state_d = IDLE;
                    end else begin
                        state_d = (state_q == REQ_TEMP) ? REQ_PULSE : LOG;
                    end
                end else if (expire) begin
                    fault_d     = 1'b1;
                    stop_pend_d = 1'b0;
                    state_d     = IDLE;
                end else if (btn_edge) begin
                    stop_pend_d = 1'b1;
                end
            end
            LOG: begin
                if (xfer) begin
                    seq_d       = seq_q + 1'b1;
                    stop_pend_d = 1'b0;
                    wait_d      = WAIT_W'(SAMPLE_PERIOD - 1);
                    state_d     = stop_now ? IDLE : WAIT;
                end else if (btn_edge) begin
                    stop_pend_d = 1'b1;
                end
            end
            WAIT: begin
                if (btn_edge) begin
                    state_d = IDLE;
                end else if (wait_q == '0) begin
                    state_d = REQ_TEMP;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        adc_req_d  = is_req(state_d);
        adc_ch_d   = (state_d == REQ_PULSE) ? CH_PULSE : CH_TEMP;
        db_valid_d = (state_d == LOG);
        active_d   = (state_d != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            button_q    <= 1'b0;
            stop_pend_q <= 1'b0;
            temp_q      <= '0;
            pulse_q     <= '0;
            seq_q       <= '0;
            wait_q      <= '0;
            fault_q     <= 1'b0;
            adc_req_q   <= 1'b0;
            adc_ch_q    <= 1'b0;
            db_valid_q  <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            button_q    <= button;
            stop_pend_q <= stop_pend_d;
            temp_q      <= temp_d;
            pulse_q     <= pulse_d;
            seq_q       <= seq_d;
            wait_q      <= wait_d;
            fault_q     <= fault_d;
            adc_req_q   <= adc_req_d;
            adc_ch_q    <= adc_ch_d;
            db_valid_q  <= db_valid_d;
            active_q    <= active_d;
        end
    end

    assign adc_req  = adc_req_q;
    assign adc_ch   = adc_ch_q;
    assign db_valid = db_valid_q;
    assign db_temp  = temp_q;
    assign db_pulse = pulse_q;
    assign db_seq   = seq_q;
    assign active   = active_q;
    assign fault    = fault_q;

`ifdef SESSION_STATS_EN
    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (start) begin
            count_d = '0;
        end else if (xfer && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign record_count = count_q;
`endif

endmodule

// File: tb/tb_session_scheduler.sv
// Bench for session_scheduler: directed scenarios plus random traffic, checked every
// cycle against a phase-level reference model of the session rules.
module tb_session_scheduler;

    localparam int unsigned ADC_W = 12;
    localparam int unsigned SP    = 8;
    localparam int unsigned TO    = 255;

    localparam int P_IDLE  = 0;
    localparam int P_TEMP  = 1;
    localparam int P_PULSE = 2;
    localparam int P_LOG   = 3;
    localparam int P_WAIT  = 4;

    logic             clock    = 1'b0;
    logic             reset    = 1'b1;
    logic             button   = 1'b0;
    logic             adc_ack  = 1'b0;
    logic [ADC_W-1:0] adc_data = '0;
    logic             db_ready = 1'b0;
    logic             adc_req, adc_ch, db_valid, active, fault;
    logic [ADC_W-1:0] db_temp, db_pulse;
    logic [7:0]       db_seq;
`ifdef SESSION_STATS_EN
    logic [15:0]      record_count;
`endif

    int checks   = 0;
    int failures = 0;

    bit fixed_mode = 1'b1;
    bit silent     = 1'b0;
    int ack_delay  = 3;
    int rsp_cnt;
    int rsp_need;

    // Reference model state
    int m_phase, m_btn, m_stop, m_age, m_since, m_temp, m_pulse, m_seq, m_fault, m_count;

    session_scheduler #(
        .ADC_W         (ADC_W),
        .SAMPLE_PERIOD (SP),
        .ADC_TIMEOUT   (TO)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .button   (button),
        .adc_ack  (adc_ack),
        .adc_data (adc_data),
        .adc_req  (adc_req),
        .adc_ch   (adc_ch),
        .db_ready (db_ready),
        .db_valid (db_valid),
        .db_temp  (db_temp),
        .db_pulse (db_pulse),
        .db_seq   (db_seq),
        .active   (active),
        .fault    (fault)
`ifdef SESSION_STATS_EN
        ,
        .record_count (record_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic press();
        button = 1'b1;
        tick(1);
        button = 1'b0;
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_btn = 0; m_stop = 0; m_age = 0; m_since = 0;
        m_temp = 0; m_pulse = 0; m_seq = 0; m_fault = 0; m_count = 0;
    endtask

    // Advances the model across one rising edge using the inputs the DUT will sample.
    task automatic model_step();
        bit edge_now;
        edge_now = button && (m_btn == 0);
        m_btn = int'(button);
        case (m_phase)
            P_IDLE: begin
                if (edge_now) begin
                    m_phase = P_TEMP; m_age = 0; m_fault = 0; m_count = 0;
                end
            end
            P_TEMP, P_PULSE: begin
                if (adc_ack) begin
                    if (m_phase == P_TEMP) m_temp = int'(adc_data);
                    else m_pulse = int'(adc_data);
                    if (m_stop != 0 || edge_now) begin
                        m_phase = P_IDLE; m_stop = 0;
                    end else begin
                        m_phase = (m_phase == P_TEMP) ? P_PULSE : P_LOG;
                        m_age = 0;
                    end
                end else if (m_age + 1 == int'(TO)) begin
                    m_fault = 1; m_phase = P_IDLE; m_stop = 0;
                end else begin
                    m_age++;
                    if (edge_now) m_stop = 1;
                end
            end
            P_LOG: begin
                if (db_ready) begin
                    m_seq = (m_seq + 1) % 256;
                    if (m_count < 65535) m_count++;
                    if (m_stop != 0 || edge_now) m_phase = P_IDLE;
                    else begin
                        m_phase = P_WAIT; m_since = 0;
                    end
                    m_stop = 0;
                end else if (edge_now) begin
                    m_stop = 1;
                end
            end
            default: begin
                if (edge_now) m_phase = P_IDLE;
                else begin
                    m_since++;
                    if (m_since == int'(SP)) begin
                        m_phase = P_TEMP; m_age = 0;
                    end
                end
            end
        endcase
    endtask

    task automatic model_check();
        chk("adc_req", adc_req, (m_phase == P_TEMP) || (m_phase == P_PULSE));
        chk("adc_ch", adc_ch, m_phase == P_PULSE);
        chk("db_valid", db_valid, m_phase == P_LOG);
        chk("active", active, m_phase != P_IDLE);
        chk("fault", fault, m_fault);
        chk("db_seq", db_seq, m_seq);
        if (m_phase == P_LOG) begin
            chk("db_temp", db_temp, m_temp);
            chk("db_pulse", db_pulse, m_pulse);
        end
`ifdef SESSION_STATS_EN
        chk("record_count", record_count, m_count);
`endif
    endtask

    // Compare process: outputs checked on the falling edge, then the model advances.
    initial begin
        model_reset();
        forever begin
            @(negedge clock);
            if (reset) model_reset();
            model_check();
            if (!reset) model_step();
        end
    end

    // ADC responder: acks after a configurable or random delay, plus stray acks when idle.
    initial begin
        rsp_cnt = 0;
        rsp_need = 3;
        forever begin
            @(posedge clock);
            #1;
            if (adc_ack) begin
                adc_ack = 1'b0;
                rsp_cnt = 0;
            end else if (adc_req && !silent) begin
                if (rsp_cnt == 0) rsp_need = fixed_mode ? ack_delay : int'($urandom_range(1, 8));
                rsp_cnt++;
                if (rsp_cnt >= rsp_need) begin
                    adc_ack = 1'b1;
                    adc_data = fixed_mode ? (adc_ch ? 12'h123 : 12'h7D0) : ADC_W'($urandom);
                end
            end else begin
                rsp_cnt = 0;
                if (!fixed_mode && !adc_req && ($urandom_range(0, 7) == 0)) begin
                    adc_ack = 1'b1;
                    adc_data = ADC_W'($urandom);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        bit ok;
        logic [7:0] prev;

        // Reset state
        tick(3);
        chk("rst_adc_req", adc_req, 0);
        chk("rst_db_valid", db_valid, 0);
        chk("rst_active", active, 0);
        chk("rst_fault", fault, 0);
        chk("rst_db_seq", db_seq, 0);
        reset = 1'b0;
        tick(1);

        // Normal record cycle
        db_ready = 1'b1;
        press();
        chk("start_req", adc_req, 1);
        chk("start_ch", adc_ch, 0);
        n = 0;
        while (!db_valid && n < 60) begin tick(1); n++; end
        chk("log_reached", db_valid, 1);
        chk("rec0_temp", db_temp, 12'h7D0);
        chk("rec0_pulse", db_pulse, 12'h123);
        chk("rec0_seq", db_seq, 0);
        tick(1);
        chk("rec0_valid_drop", db_valid, 0);
        chk("rec0_seq_inc", db_seq, 1);
        n = 0;
        while (!adc_req && n < 100) begin tick(1); n++; end
        chk("period", n, SP);

        // Backpressure
        db_ready = 1'b0;
        n = 0;
        while (!db_valid && n < 60) begin tick(1); n++; end
        tick(20);
        chk("bp_valid_held", db_valid, 1);
        chk("bp_temp_held", db_temp, 12'h7D0);
        db_ready = 1'b1;
        tick(1);
        chk("bp_valid_drop", db_valid, 0);
        chk("bp_seq", db_seq, 2);

        // Stop during REQ_PULSE
        ack_delay = 8;
        n = 0;
        while (!(adc_req && adc_ch) && n < 100) begin tick(1); n++; end
        press();
        chk("stop_still_req", adc_req, 1);
        n = 0;
        while (adc_req && n < 60) begin tick(1); n++; end
        chk("stop_req_drop", adc_req, 0);
        chk("stop_idle", active, 0);
        tick(3);
        chk("stop_no_log", db_valid, 0);
        chk("stop_seq_kept", db_seq, 2);

        // ADC timeout
        ack_delay = 3;
        silent = 1'b1;
        press();
        chk("to_req", adc_req, 1);
        n = 0;
        while (adc_req && n < 400) begin tick(1); n++; end
        chk("to_cycles", n, TO);
        chk("to_fault", fault, 1);
        chk("to_idle", active, 0);
        silent = 1'b0;
        press();
        chk("restart_fault_clr", fault, 0);
        chk("restart_req", adc_req, 1);

        // Random traffic
        fixed_mode = 1'b0;
        repeat (1500) begin
            db_ready = 1'($urandom_range(0, 1));
            button = ($urandom_range(0, 39) == 0);
            tick(1);
        end
        button = 1'b0;
        db_ready = 1'b1;

        // Sequence wrap
        fixed_mode = 1'b1;
        ack_delay = 1;
        tick(30);
        if (!active) press();
        ok = 1'b0;
        prev = db_seq;
        n = 0;
        while (!ok && n < 8000) begin
            tick(1);
            n++;
            if (db_seq != prev) begin
                if (prev == 8'hFF) ok = (db_seq == 8'h00);
                prev = db_seq;
            end
        end
        chk("seq_wrap", ok, 1);
        chk("seq_after_wrap", db_seq, 0);

        // Async reset while a record is pending
        db_ready = 1'b0;
        n = 0;
        while (!db_valid && n < 60) begin tick(1); n++; end
        chk("pre_reset_log", db_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_valid", db_valid, 0);
        chk("areset_seq", db_seq, 0);
        chk("areset_active", active, 0);
        chk("areset_req", adc_req, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        db_ready = 1'b1;
        tick(1);

`ifdef SESSION_STATS_EN
        // Record statistics
        ack_delay = 2;
        press();
        n = 0;
        while (db_seq != 8'd3 && n < 300) begin tick(1); n++; end
        chk("stats_three", record_count, 3);
        press();
        n = 0;
        while (active && n < 100) begin tick(1); n++; end
        chk("stats_stopped", active, 0);
        press();
        chk("stats_cleared", record_count, 0);
        press();
        tick(30);
`endif

        tick(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
